// File: rtl/sop_abs_diff_engine.sv
// Configurable shared-product SOP evaluator for |a-b| approximations with a
// two-stage valid/ready pipeline and an on-line error/violation monitor.
module sop_abs_diff_engine #(
    parameter int W   = 2,
    parameter int PIT = 4,
    parameter int ET  = 1,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [5*W-1:0] cfg_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  approx,
    output logic [W-1:0]  exact,
    output logic [W-1:0]  err,
    output logic          viol,
    output logic          configured,
    output logic [CW-1:0] sample_cnt,
    output logic [CW-1:0] viol_cnt,
    output logic [W-1:0]  max_err,
    input  logic          stat_clr
);

    localparam int NI   = 2 * W;
    localparam int CFGW = 5 * W;
    localparam int IW   = (PIT > 1) ? $clog2(PIT) : 1;
    localparam logic [W-1:0] ET_W = W'(ET);

    typedef enum logic [1:0] {S_UNCFG, S_LOAD, S_RUN, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CFGW-1:0] cfg_q [PIT];

    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    logic [PIT-1:0]  prod_q, prod_d;
    logic [W-1:0]    exact1_q;
    logic [W-1:0]    approx_q, exact_q, err_q, max_err_q;
    logic            viol_q;
    logic [CW-1:0]   sample_cnt_q, viol_cnt_q;

    logic            advance, in_fire, out_fire, cfg_fire;
    logic            pipe_empty, empty_next;
    logic [NI-1:0]   in_vec;
    logic [W-1:0]    exact_c, approx_c, err_c;

    assign advance    = ~s2_valid_q | out_ready;
    assign in_ready   = (state_q == S_RUN) & advance;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = s2_valid_q & out_ready;
    assign cfg_fire   = cfg_valid & cfg_ready & ~cfg_start;
    assign s1_valid_d = advance ? in_fire : s1_valid_q;
    assign s2_valid_d = advance ? s1_valid_q : s2_valid_q;
    assign pipe_empty = ~s1_valid_q & ~s2_valid_q;
    assign empty_next = ~s1_valid_d & ~s2_valid_d;

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cfg_ready = 1'b0;
        case (state_q)
            S_UNCFG: begin
                if (cfg_start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_start) begin
                    idx_d = '0;
                end else if (cfg_valid) begin
                    if (idx_q == IW'(PIT - 1)) state_d = S_RUN;
                    else                        idx_d   = idx_q + 1'b1;
                end
            end
            S_RUN: begin
                // A sample entering this very cycle must drain under the old config.
                if (cfg_start) begin
                    idx_d   = '0;
                    state_d = (pipe_empty && !in_fire) ? S_LOAD : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (empty_next) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            default: state_d = S_UNCFG;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_UNCFG;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // NOTE: the slot array is reset because a reset must discard any partial configuration.
    always_ff @(posedge clk) begin
        if (rst)           cfg_q        <= '{default: '0};
        else if (cfg_fire) cfg_q[idx_q] <= cfg_data;
    end

    assign in_vec  = {b, a};
    assign exact_c = (a >= b) ? (a - b) : (b - a);

    // A used literal is true when the input bit equals its polarity bit.
    always_comb begin
        prod_d = '1;
        for (int p = 0; p < PIT; p++) begin
            for (int i = 0; i < NI; i++) begin
                if (cfg_q[p][2*i+1] && (cfg_q[p][2*i] != in_vec[i])) prod_d[p] = 1'b0;
            end
        end
    end

    always_comb begin
        approx_c = '0;
        for (int p = 0; p < PIT; p++) begin
            for (int k = 0; k < W; k++) begin
                if (prod_q[p] && cfg_q[p][2*NI+k]) approx_c[k] = 1'b1;
            end
        end
    end

    assign err_c = (approx_c >= exact1_q) ? (approx_c - exact1_q) : (exact1_q - approx_c);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            exact1_q   <= '0;
            approx_q   <= '0;
            exact_q    <= '0;
            err_q      <= '0;
            viol_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (advance && in_fire) begin
                prod_q   <= prod_d;
                exact1_q <= exact_c;
            end
            if (advance && s1_valid_q) begin
                approx_q <= approx_c;
                exact_q  <= exact1_q;
                err_q    <= err_c;
                viol_q   <= (err_c > ET_W);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            sample_cnt_q <= '0;
            viol_cnt_q   <= '0;
            max_err_q    <= '0;
        end else if (out_fire) begin
            if (sample_cnt_q != '1)          sample_cnt_q <= sample_cnt_q + 1'b1;
            if (viol_q && viol_cnt_q != '1)  viol_cnt_q   <= viol_cnt_q + 1'b1;
            if (err_q > max_err_q)           max_err_q    <= err_q;
        end
    end

    assign out_valid  = s2_valid_q;
    assign approx     = approx_q;
    assign exact      = exact_q;
    assign err        = err_q;
    assign viol       = viol_q;
    assign configured = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign sample_cnt = sample_cnt_q;
    assign viol_cnt   = viol_cnt_q;
    assign max_err    = max_err_q;

endmodule

// File: tb/tb_sop_abs_diff_engine.sv
// Directed bench for sop_abs_diff_engine (W=2, PIT=4, ET=1, CW=4) with
// hand-computed expectations for the reference and all-zero configurations.
module tb_sop_abs_diff_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_start = 1'b0, cfg_valid = 1'b0, cfg_ready;
    logic [9:0] cfg_data = '0;
    logic       in_valid = 1'b0, in_ready;
    logic [1:0] a = '0, b = '0;
    logic       out_valid, out_ready = 1'b1;
    logic [1:0] approx, exact, err, max_err;
    logic       viol, configured;
    logic [3:0] sample_cnt, viol_cnt;
    logic       stat_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    // Reference words: p0=~a1&b1->o1, p1=a0&b0->o0, p2=a0&~b0->o1, p3=~a0&~b0->o0
    localparam logic [9:0] W_P0 = 10'b10_1100_1000;
    localparam logic [9:0] W_P1 = 10'b01_0011_0011;
    localparam logic [9:0] W_P2 = 10'b10_0010_0011;
    localparam logic [9:0] W_P3 = 10'b01_0010_0010;

    logic [1:0] sa[$], sb[$];
    logic [1:0] cap_approx[$], cap_exact[$], cap_err[$];
    logic       cap_viol[$];
    int         sent_at_stall;
    logic       inr_at_stall;

    sop_abs_diff_engine #(.W(2), .PIT(4), .ET(1), .CW(4)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .approx(approx), .exact(exact), .err(err), .viol(viol),
        .configured(configured), .sample_cnt(sample_cnt), .viol_cnt(viol_cnt),
        .max_err(max_err), .stat_clr(stat_clr)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [9:0] w0, input logic [9:0] w1,
                              input logic [9:0] w2, input logic [9:0] w3);
        logic [9:0] w;
        for (int j = 0; j < 4; j++) begin
            case (j)
                0: w = w0;
                1: w = w1;
                2: w = w2;
                default: w = w3;
            endcase
            cfg_valid = 1'b1;
            cfg_data  = w;
            #3;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++; $display("FAIL load_cfg_ready word %0d: got %b want 1", j, cfg_ready);
            end
            if (j == 3) begin
                checks++;
                if (configured !== 1'b0) begin
                    errors++; $display("FAIL load_configured_early: got %b want 0", configured);
                end
            end
            next();
        end
        cfg_valid = 1'b0;
        #3;
        checks++;
        if (configured !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_done: got configured=%b in_ready=%b want 1 1", configured, in_ready);
        end
        next();
    endtask

    task automatic cfg_load(input logic [9:0] w0, input logic [9:0] w1,
                            input logic [9:0] w2, input logic [9:0] w3);
        cfg_start = 1'b1;
        next();
        cfg_start = 1'b0;
        load_words(w0, w1, w2, w3);
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
    endtask

    // Streams sa/sb in order; out_ready held low for the first 'stall' cycles.
    task automatic run_stream(input int n, input int stall);
        int sent = 0, got = 0, cyc = 0;
        logic fire, holding = 1'b0;
        logic [6:0] held = '0;
        cap_approx.delete(); cap_exact.delete(); cap_err.delete(); cap_viol.delete();
        sent_at_stall = -1;
        inr_at_stall  = 1'bx;
        while (got < n && cyc < 100) begin
            in_valid  = (sent < n);
            a         = (sent < n) ? sa[sent] : 2'd0;
            b         = (sent < n) ? sb[sent] : 2'd0;
            out_ready = (cyc >= stall);
            #3;
            fire = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                if (holding) begin
                    checks++;
                    if ({approx, exact, err, viol} !== held) begin
                        errors++;
                        $display("FAIL hold_stable cycle %0d: got %h want %h", cyc, {approx, exact, err, viol}, held);
                    end
                end
                held    = {approx, exact, err, viol};
                holding = 1'b1;
            end else begin
                holding = 1'b0;
            end
            if (stall > 0 && cyc == stall - 1) begin
                sent_at_stall = sent + (fire ? 1 : 0);
                inr_at_stall  = in_ready;
            end
            if (out_valid && out_ready) begin
                cap_approx.push_back(approx);
                cap_exact.push_back(exact);
                cap_err.push_back(err);
                cap_viol.push_back(viol);
                got++;
            end
            next();
            if (fire) sent++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (got != n) begin
            errors++; $display("FAIL stream_timeout: got %0d outputs want %0d", got, n);
        end
    endtask

    task automatic check_ref_outputs(input string tag);
        logic [1:0] ea[4] = '{2'd1, 2'd2, 2'd2, 2'd3};
        logic [1:0] ee[4] = '{2'd0, 2'd1, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= cap_approx.size()) begin
                errors++; $display("FAIL %s sample %0d: missing output", tag, i);
            end else if (cap_approx[i] !== ea[i] || cap_exact[i] !== ee[i] ||
                         cap_err[i] !== 2'd1 || cap_viol[i] !== 1'b0) begin
                errors++;
                $display("FAIL %s sample %0d: got approx=%0d exact=%0d err=%0d viol=%b want %0d %0d 1 0",
                         tag, i, cap_approx[i], cap_exact[i], cap_err[i], cap_viol[i], ea[i], ee[i]);
            end
        end
    endtask

    task automatic set_ref_stream(input int n);
        logic [1:0] ra[4] = '{2'd0, 2'd1, 2'd3, 2'd0};
        logic [1:0] rb[4] = '{2'd0, 2'd2, 2'd0, 2'd2};
        sa.delete(); sb.delete();
        for (int i = 0; i < n; i++) begin
            sa.push_back(ra[i % 4]);
            sb.push_back(rb[i % 4]);
        end
    endtask

    task automatic test_reset();
        repeat (3) next();
        rst = 1'b0;
        #3;
        checks++;
        if ({cfg_ready, in_ready, out_valid, configured} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got cfg_ready/in_ready/out_valid/configured=%b want 0000",
                     {cfg_ready, in_ready, out_valid, configured});
        end
        checks++;
        if ({approx, exact, err, viol} !== 7'd0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {approx, exact, err, viol});
        end
        checks++;
        if ({sample_cnt, viol_cnt, max_err} !== 10'd0) begin
            errors++; $display("FAIL reset_stats: got %h want 0", {sample_cnt, viol_cnt, max_err});
        end
        next();
    endtask

    task automatic test_reset_midload();
        cfg_start = 1'b1;
        next();
        cfg_start = 1'b0;
        cfg_valid = 1'b1; cfg_data = W_P0; next();
        cfg_data = W_P1; next();
        cfg_valid = 1'b0;
        rst = 1'b1;
        next();
        rst = 1'b0;
        #3;
        checks++;
        if ({configured, in_ready, cfg_ready} !== 3'b000) begin
            errors++;
            $display("FAIL midload_reset: got configured/in_ready/cfg_ready=%b want 000",
                     {configured, in_ready, cfg_ready});
        end
        next();
        cfg_load(W_P0, W_P1, W_P2, W_P3);
        sa.delete(); sb.delete();
        sa.push_back(2'd0); sb.push_back(2'd2);
        run_stream(1, 0);
        checks++;
        if (cap_approx.size() != 1 || cap_approx[0] !== 2'd3) begin
            errors++; $display("FAIL midload_reload: got approx=%0d want 3", cap_approx[0]);
        end
    endtask

    task automatic test_reference();
        clear_stats();
        set_ref_stream(4);
        run_stream(4, 0);
        check_ref_outputs("reference");
        #3;
        checks++;
        if (sample_cnt !== 4'd4 || viol_cnt !== 4'd0 || max_err !== 2'd1) begin
            errors++;
            $display("FAIL reference_stats: got sample=%0d viol=%0d max=%0d want 4 0 1",
                     sample_cnt, viol_cnt, max_err);
        end
        next();
    endtask

    task automatic test_backpressure();
        set_ref_stream(4);
        run_stream(4, 5);
        checks++;
        if (sent_at_stall != 2 || inr_at_stall !== 1'b0) begin
            errors++;
            $display("FAIL stall_inready: got accepted=%0d in_ready=%b want 2 0", sent_at_stall, inr_at_stall);
        end
        check_ref_outputs("backpressure");
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL no_duplicate cycle %0d: got out_valid=%b want 0", i, out_valid);
            end
            next();
        end
    endtask

    task automatic test_reconfig_drain();
        in_valid = 1'b1; a = 2'd1; b = 2'd2;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_accept0: got in_ready=%b want 1", in_ready);
        end
        next();
        a = 2'd3; b = 2'd0;
        #3;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL drain_accept1: got in_ready=%b want 1", in_ready);
        end
        next();
        in_valid = 1'b0; out_ready = 1'b0; cfg_start = 1'b1;
        next();
        cfg_start = 1'b0;
        #3;
        checks++;
        if ({cfg_ready, in_ready, out_valid} !== 3'b001 || approx !== 2'd2 || exact !== 2'd1) begin
            errors++;
            $display("FAIL drain_first: got rdy/inr/ov=%b approx=%0d exact=%0d want 001 2 1",
                     {cfg_ready, in_ready, out_valid}, approx, exact);
        end
        out_ready = 1'b1;
        next();
        #3;
        checks++;
        if ({cfg_ready, out_valid} !== 2'b01 || approx !== 2'd2 || exact !== 2'd3) begin
            errors++;
            $display("FAIL drain_second: got rdy/ov=%b approx=%0d exact=%0d want 01 2 3",
                     {cfg_ready, out_valid}, approx, exact);
        end
        next();
        #3;
        checks++;
        if ({cfg_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL drain_exit: got cfg_ready/out_valid=%b want 10", {cfg_ready, out_valid});
        end
        load_words(10'd0, 10'd0, 10'd0, 10'd0);
        clear_stats();
        sa.delete(); sb.delete();
        sa.push_back(2'd3); sb.push_back(2'd0);
        run_stream(1, 0);
        checks++;
        if (cap_approx.size() != 1 || cap_approx[0] !== 2'd0 || cap_exact[0] !== 2'd3 ||
            cap_err[0] !== 2'd3 || cap_viol[0] !== 1'b1) begin
            errors++;
            $display("FAIL zero_cfg: got approx=%0d exact=%0d err=%0d viol=%b want 0 3 3 1",
                     cap_approx[0], cap_exact[0], cap_err[0], cap_viol[0]);
        end
        #3;
        checks++;
        if (max_err !== 2'd3 || viol_cnt !== 4'd1 || sample_cnt !== 4'd1) begin
            errors++;
            $display("FAIL zero_stats: got max=%0d viol=%0d sample=%0d want 3 1 1", max_err, viol_cnt, sample_cnt);
        end
        next();
    endtask

    task automatic test_sat_clear();
        cfg_load(W_P0, W_P1, W_P2, W_P3);
        clear_stats();
        set_ref_stream(20);
        run_stream(20, 0);
        #3;
        checks++;
        if (sample_cnt !== 4'd15 || viol_cnt !== 4'd0 || max_err !== 2'd1) begin
            errors++;
            $display("FAIL saturate: got sample=%0d viol=%0d max=%0d want 15 0 1", sample_cnt, viol_cnt, max_err);
        end
        next();
        in_valid = 1'b1; a = 2'd3; b = 2'd0; out_ready = 1'b0;
        next();
        in_valid = 1'b0;
        next();
        #3;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL clr_setup: got out_valid=%b want 1", out_valid);
        end
        out_ready = 1'b1; stat_clr = 1'b1;
        next();
        stat_clr = 1'b0;
        #3;
        checks++;
        if ({sample_cnt, viol_cnt, max_err} !== 10'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: got sample=%0d viol=%0d max=%0d ov=%b want 0 0 0 0",
                     sample_cnt, viol_cnt, max_err, out_valid);
        end
        next();
    endtask

    initial begin
        test_reset();
        test_reset_midload();
        test_reference();
        test_backpressure();
        test_reconfig_drain();
        test_sat_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
